// File: rtl/adder_share_arb_if.sv
// Bundle of the request and response channels between the arithmetic clients
// and the shared adder sequencer. The arbiter takes the slave side.
interface adder_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that lets NREQ clients share one registered adder.
// One transaction walks IDLE (grant) -> CALC (add) -> RESP (hand result back).
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    adder_share_arb_if.slave  bus
);

    localparam int PW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   idx_q;
    logic [WIDTH-1:0] opA_q, opB_q;
    logic [WIDTH-1:0] rspSum_q;
    logic             rspCarry_q;
    logic [IDW-1:0]   rspId_q;
    logic             rspValid_q;

    logic             found;
    logic [IDW-1:0]   winId;
    logic [PW-1:0]    pos;
    logic [WIDTH-1:0] selA, selB;
    logic [NREQ-1:0]  grant;

    // Scan requesters from the priority pointer upward with wrap; first valid one wins.
    always_comb begin
        found = 1'b0;
        winId = '0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr_q} + PW'(k);
            if (pos >= PW'(NREQ)) begin
                pos = pos - PW'(NREQ);
            end
            if (!found && bus.req_valid[pos[IDW-1:0]]) begin
                found = 1'b1;
                winId = pos[IDW-1:0];
            end
        end
    end

    // Select the winner's operand slices and build the one-hot grant, which is only offered in IDLE.
    always_comb begin
        selA  = '0;
        selB  = '0;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == winId) begin
                selA     = bus.req_a[i*WIDTH +: WIDTH];
                selB     = bus.req_b[i*WIDTH +: WIDTH];
                grant[i] = found && (state_q == IDLE) && !rst;
            end
        end
    end

    // Next-state logic; the pointer moves past the served requester once its result is taken.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = (idx_q == IDW'(NREQ - 1)) ? '0 : idx_q + IDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Operand capture on grant, the single shared add in CALC, and response valid tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opA_q      <= '0;
            opB_q      <= '0;
            idx_q      <= '0;
            rspSum_q   <= '0;
            rspCarry_q <= 1'b0;
            rspId_q    <= '0;
            rspValid_q <= 1'b0;
        end else begin
            if (state_q == IDLE && found) begin
                opA_q <= selA;
                opB_q <= selB;
                idx_q <= winId;
            end
            if (state_q == CALC) begin
                {rspCarry_q, rspSum_q} <= {1'b0, opA_q} + {1'b0, opB_q};
                rspId_q    <= idx_q;
                rspValid_q <= 1'b1;
            end
            if (state_q == RESP && bus.rsp_ready) begin
                rspValid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_id    = rspId_q;
    assign bus.rsp_sum   = rspSum_q;
    assign bus.rsp_carry = rspCarry_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios plus random batches, with a
// transaction-level round-robin model feeding grant and response scoreboards.
module tb_adder_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    typedef struct {
        int id;
        int sum;
        int carry;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    adder_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   expGrantQ[$];
    rsp_t expRspQ[$];
    int   modelPtr = 0;
    bit   forceLow = 1'b0;
    int   stimA[NREQ];
    int   stimB[NREQ];
    int   lat = -1;
    int   monGrant;
    rsp_t monRsp;

    // Single place where a comparison is counted and reported.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic setOp(input int i, input int a, input int b);
        stimA[i] = a;
        stimB[i] = b;
    endtask

    // Raise a batch of requests at once and predict the whole service order:
    // repeatedly pick the first pending requester at or after the pointer.
    task automatic applyStimulus(input logic [NREQ-1:0] mask);
        bit   pending[NREQ];
        int   idx;
        int   total;
        rsp_t r;
        int   left;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = mask[i];
            if (mask[i]) begin
                bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(stimA[i]);
                bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(stimB[i]);
                left++;
            end
        end
        while (left > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (modelPtr + k) % NREQ;
                if (pending[idx]) begin
                    total   = stimA[idx] + stimB[idx];
                    r.id    = idx;
                    r.sum   = total % (1 << WIDTH);
                    r.carry = (total >= (1 << WIDTH)) ? 1 : 0;
                    expGrantQ.push_back(idx);
                    expRspQ.push_back(r);
                    pending[idx] = 1'b0;
                    modelPtr = (idx + 1) % NREQ;
                    left--;
                    break;
                end
            end
        end
        bus.req_valid = bus.req_valid | mask;
    endtask

    // One clock: note grants before the edge, then drop granted requests and pick rsp_ready.
    task automatic tick(output logic [NREQ-1:0] g);
        @(negedge clk);
        g = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~g;
        bus.rsp_ready = forceLow ? 1'b0 : ($urandom_range(3) != 0);
    endtask

    task automatic flushModel();
        expGrantQ.delete();
        expRspQ.delete();
        modelPtr      = 0;
        bus.req_valid = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, int'(bus.req_ready), 0);
        checkOutput({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        checkOutput({tag, "_rsp_id"},    int'(bus.rsp_id), 0);
        checkOutput({tag, "_rsp_sum"},   int'(bus.rsp_sum), 0);
        checkOutput({tag, "_rsp_carry"}, int'(bus.rsp_carry), 0);
        checkOutput({tag, "_busy"},      int'(bus.busy), 0);
    endtask

    task automatic pulseReset();
        logic [NREQ-1:0] g;
        rst = 1'b1;
        flushModel();
        tick(g);
        rst = 1'b0;
    endtask

    // Run until every predicted response has been consumed, within a cycle budget.
    task automatic waitDone();
        int n;
        logic [NREQ-1:0] g;
        n = 0;
        while ((expRspQ.size() != 0 || bus.req_valid != '0) && n < 400) begin
            tick(g);
            n++;
        end
        checkOutput("batch_completes", int'(n < 400), 1);
        if (n >= 400) begin
            pulseReset();
        end
    endtask

    // Monitor: checks grants, CALC/RESP timing and response contents against the queues.
    always @(negedge clk) begin
        if (rst) begin
            lat = -1;
        end else begin
            if (lat >= 0) begin
                lat++;
            end
            if (lat == 1) begin
                checkOutput("calc_rsp_valid_low", int'(bus.rsp_valid), 0);
                checkOutput("calc_req_ready_low", int'(bus.req_ready), 0);
            end
            if (lat == 2) begin
                checkOutput("latency_rsp_valid", int'(bus.rsp_valid), 1);
                lat = -1;
            end
            if (bus.rsp_valid) begin
                checkOutput("resp_req_ready_zero", int'(bus.req_ready), 0);
                checkOutput("resp_busy", int'(bus.busy), 1);
                checkOutput("rsp_expected", int'(expRspQ.size() != 0), 1);
                if (expRspQ.size() != 0) begin
                    monRsp = expRspQ[0];
                    checkOutput("rsp_id", int'(bus.rsp_id), monRsp.id);
                    checkOutput("rsp_sum", int'(bus.rsp_sum), monRsp.sum);
                    checkOutput("rsp_carry", int'(bus.rsp_carry), monRsp.carry);
                    if (bus.rsp_ready) begin
                        void'(expRspQ.pop_front());
                    end
                end
            end
            if (bus.req_ready != '0) begin
                checkOutput("grant_expected", int'(expGrantQ.size() != 0), 1);
                checkOutput("idle_busy", int'(bus.busy), 0);
                if (expGrantQ.size() != 0) begin
                    monGrant = expGrantQ.pop_front();
                    checkOutput("grant_onehot", int'(bus.req_ready), 1 << monGrant);
                end
                lat = 0;
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random batches.
    initial begin
        logic [NREQ-1:0] g;
        int n;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #12;
        bus.req_valid = '1;
        #1;
        checkResetOutputs("reset");
        bus.req_valid = '0;
        tick(g);
        tick(g);
        rst = 1'b0;

        // Single request, then overflow cases on requester 2.
        setOp(0, 5, 1);
        applyStimulus(4'b0001);
        waitDone();
        setOp(2, 200, 100);
        applyStimulus(4'b0100);
        waitDone();
        setOp(2, 255, 255);
        applyStimulus(4'b0100);
        waitDone();

        // Fairness from a fresh pointer: order 0,1,2,3 then 0 again.
        pulseReset();
        setOp(0, 3, 7);
        setOp(1, 1, 1);
        setOp(2, 10, 20);
        setOp(3, 128, 128);
        applyStimulus(4'b1111);
        waitDone();
        setOp(0, 3, 7);
        applyStimulus(4'b0001);
        waitDone();

        // Response backpressure with another request pending.
        forceLow = 1'b1;
        setOp(1, 50, 60);
        setOp(3, 250, 9);
        applyStimulus(4'b1010);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick(g);
            n++;
        end
        checkOutput("bp_rsp_seen", int'(bus.rsp_valid), 1);
        repeat (5) tick(g);
        forceLow = 1'b0;
        waitDone();

        // After requester 1 is served, 3 beats 0.
        setOp(1, 11, 22);
        applyStimulus(4'b0010);
        waitDone();
        setOp(0, 100, 27);
        setOp(3, 17, 240);
        applyStimulus(4'b1001);
        waitDone();
        setOp(1, 40, 2);
        applyStimulus(4'b0010);
        waitDone();

        // Reset while in CALC.
        setOp(3, 9, 9);
        applyStimulus(4'b1000);
        g = '0;
        n = 0;
        while (g == '0 && n < 20) begin
            tick(g);
            n++;
        end
        checkOutput("calc_grant_seen", int'(g), 4'b1000);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_calc");
        flushModel();
        tick(g);
        tick(g);
        rst = 1'b0;
        repeat (3) tick(g);

        // Reset while in RESP.
        forceLow = 1'b1;
        setOp(2, 77, 200);
        applyStimulus(4'b0100);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick(g);
            n++;
        end
        checkOutput("resp_rsp_seen", int'(bus.rsp_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_resp");
        flushModel();
        forceLow = 1'b0;
        tick(g);
        rst = 1'b0;
        repeat (3) tick(g);

        // Pointer restarts at 0 after reset.
        setOp(0, 1, 2);
        setOp(2, 3, 4);
        setOp(3, 5, 6);
        applyStimulus(4'b1101);
        waitDone();

        // Random batches with random backpressure.
        repeat (80) begin
            for (int i = 0; i < NREQ; i++) begin
                setOp(i, int'($urandom_range(255)), int'($urandom_range(255)));
            end
            applyStimulus(NREQ'($urandom_range(15, 1)));
            waitDone();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered WIDTH-bit adder between NREQ requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- The block grants one requester, performs {carry,sum} = a + b, and returns the result with the requester's index on a single valid/ready response channel.
- Sits between several arithmetic clients and the team's single adder datapath, so only one adder instance is needed.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and sum width in bits.
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NREQ  bit i: requester i offers an operand pair.
- req_ready  output  NREQ  one-hot grant/accept; bit i high means requester i's pair is taken this cycle.
- req_a  input  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b, same packing as req_a.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_sum  output  WIDTH  a + b, modulo 2**WIDTH.
- rsp_carry  output  1  carry-out of a + b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous; takes effect immediately.
  - Outputs while rst is high: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_carry = 0, busy = 0.
  - FSM goes to IDLE and the priority pointer goes to 0.
  - Reset asserted mid-operation discards any captured operands or pending result; no response is ever produced for that transaction.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid bit is high, req_ready is driven combinationally, one-hot, for the winner.
  - Winner: the first requester with req_valid high, scanning from the pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - On a clock edge with req_valid[w] & req_ready[w]: capture req_a/req_b slice w and index w into internal registers, then go to CALC.
  - If no request is valid, req_ready = 0 and the FSM stays in IDLE.
- CALC (one cycle):
  - Register {rsp_carry, rsp_sum} = a + b as a zero-extended WIDTH+1-bit add; register rsp_id = w.
  - Set rsp_valid = 1 and go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid stays high.
  - rsp_id, rsp_sum and rsp_carry stay stable until the handshake completes.
  - On an edge with rsp_ready high: clear rsp_valid, set pointer = (w+1) mod NREQ, go to IDLE.
  - rsp_ready held low stalls indefinitely.
  - req_ready = 0 throughout RESP.
- Latency and throughput:
  - Request accepted at edge T gives rsp_valid high after edge T+1, i.e. the cycle after CALC.
  - At most one transaction every 3 cycles (IDLE, CALC, RESP with rsp_ready already high).
- Data outputs: rsp_sum, rsp_carry and rsp_id keep their last value after the response handshake; they are don't-care while rsp_valid is low.
- Requester input requirements and fairness:
  - A requester must hold req_valid and its operands until it is granted.
  - Dropping req_valid before grant is tolerated, because arbitration is recomputed every IDLE cycle.
  - A requester that keeps req_valid high waits at most NREQ-1 other transactions.
- Simultaneous events:
  - Several valid requests in the same cycle: only the round-robin winner is granted.
  - rsp_ready high in CALC has no effect.
  - A new request arriving during CALC or RESP waits for IDLE.
- Wrap-around:
  - The pointer advances mod NREQ.
  - The adder wraps mod 2**WIDTH, with the overflow reported in rsp_carry.
- busy = (state != IDLE).

Test Plan:
- Reset then single request: req_valid = 0001, a0 = 5, b0 = 1, rsp_ready = 1 -> req_ready = 0001 for one cycle; rsp_valid rises 2 edges later with rsp_id = 0, rsp_sum = 6, rsp_carry = 0; FSM back to IDLE.
- Overflow: requester 2 sends a = 200, b = 100 -> rsp_id = 2, rsp_sum = 44, rsp_carry = 1. Also a = 255, b = 255 -> rsp_sum = 254, rsp_carry = 1.
- Round-robin fairness:
  - All four requesters valid continuously with pairs (3,7), (1,1), (10,20), (128,128).
  - Expected grant order 0, 1, 2, 3, 0.
  - Expected sums 10, 2, 30, 0 with carry 1 on the last.
  - Pointer wraps correctly.
- Response backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid stays high, outputs stable, req_ready stays 0 despite pending requests; the grant occurs only after rsp_ready = 1.
- Reset mid-operation: assert rst during CALC, then during RESP -> outputs clear immediately; no response for that transaction; after release, requester 0 wins first (pointer = 0).
- Priority start: after requester 1 is served, requesters 0 and 3 both valid -> requester 3 is granted before requester 0.
